// File: rtl/qtree_match_wr.sv
// Write engine for one quadtree match stage: turns host WRITE/INVAL/ALLOC/CLEAR
// commands into per-slot RAM write strobes and keeps a shadow valid bitmap for ALLOC.
module qtree_match_wr #(
    parameter int A_WIDTH = 4,
    parameter int D_WIDTH = 16,
    parameter int D_CNT   = 4,
    parameter int S_WIDTH = $clog2(D_CNT)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [1:0]         cmd_op_i,
    input  logic [A_WIDTH-1:0] cmd_addr_i,
    input  logic [S_WIDTH-1:0] cmd_slot_i,
    input  logic [D_WIDTH-1:0] cmd_value_i,
    output logic               wr_en_o,
    output logic [A_WIDTH-1:0] wr_addr_o,
    output logic [D_CNT-1:0]   wr_sel_o,
    output logic [D_WIDTH:0]   wr_data_o,
    output logic               done_o,
    output logic               err_o,
    output logic [S_WIDTH-1:0] rsp_slot_o
);

    localparam int                 ENTRIES   = 2 ** A_WIDTH;
    localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(ENTRIES - 1);
    localparam logic [1:0]         OP_WRITE  = 2'b00;
    localparam logic [1:0]         OP_INVAL  = 2'b01;
    localparam logic [1:0]         OP_ALLOC  = 2'b10;
    localparam logic [1:0]         OP_CLEAR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_CLEAR = 2'b10
    } state_t;

    function automatic logic [D_CNT-1:0] slot_onehot(input logic [S_WIDTH-1:0] slot);
        logic [D_CNT-1:0] sel;
        for (int i = 0; i < D_CNT; i++) begin
            sel[i] = (S_WIDTH'(i) == slot);
        end
        return sel;
    endfunction

    // Returns {found, index} of the lowest clear bit.
    function automatic logic [S_WIDTH:0] lowest_free(input logic [D_CNT-1:0] used);
        logic [S_WIDTH:0] res;
        res = {1'b0, {S_WIDTH{1'b0}}};
        for (int i = D_CNT - 1; i >= 0; i--) begin
            res = used[i] ? res : {1'b1, S_WIDTH'(i)};
        end
        return res;
    endfunction

    state_t             state_r, state_s;
    logic               cmd_ready_r, cmd_ready_s;
    logic               wr_en_r, wr_en_s;
    logic [A_WIDTH-1:0] wr_addr_r, wr_addr_s;
    logic [D_CNT-1:0]   wr_sel_r, wr_sel_s;
    logic [D_WIDTH:0]   wr_data_r, wr_data_s;
    logic               done_r, done_s;
    logic               err_r, err_s;
    logic [S_WIDTH-1:0] rsp_slot_r, rsp_slot_s;
    logic [D_CNT-1:0]   shadow_r [ENTRIES];

    logic               accept_s;
    logic               slot_ok_s;
    logic [S_WIDTH:0]   free_s;
    logic               sh_set_s;
    logic               sh_val_s;
    logic               sh_clr_all_s;
    logic [S_WIDTH-1:0] sh_slot_s;

    assign accept_s  = cmd_valid_i && cmd_ready_r;
    assign slot_ok_s = int'(cmd_slot_i) < D_CNT;
    assign free_s    = lowest_free(shadow_r[cmd_addr_i]);

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_s      = state_r;
        cmd_ready_s  = 1'b0;
        wr_en_s      = 1'b0;
        wr_addr_s    = {A_WIDTH{1'b0}};
        wr_sel_s     = {D_CNT{1'b0}};
        wr_data_s    = {(D_WIDTH + 1){1'b0}};
        done_s       = 1'b0;
        err_s        = 1'b0;
        rsp_slot_s   = {S_WIDTH{1'b0}};
        sh_set_s     = 1'b0;
        sh_val_s     = 1'b0;
        sh_clr_all_s = 1'b0;
        sh_slot_s    = {S_WIDTH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd_op_i)
                        OP_WRITE, OP_INVAL: begin
                            state_s = ST_ISSUE;
                            done_s  = 1'b1;
                            if (slot_ok_s) begin
                                wr_en_s    = 1'b1;
                                wr_addr_s  = cmd_addr_i;
                                wr_sel_s   = slot_onehot(cmd_slot_i);
                                wr_data_s  = (cmd_op_i == OP_WRITE) ? {1'b1, cmd_value_i}
                                                                    : {(D_WIDTH + 1){1'b0}};
                                rsp_slot_s = cmd_slot_i;
                                sh_set_s   = 1'b1;
                                sh_val_s   = (cmd_op_i == OP_WRITE);
                                sh_slot_s  = cmd_slot_i;
                            end else begin
                                err_s = 1'b1;
                            end
                        end
                        OP_ALLOC: begin
                            state_s = ST_ISSUE;
                            done_s  = 1'b1;
                            if (free_s[S_WIDTH]) begin
                                wr_en_s    = 1'b1;
                                wr_addr_s  = cmd_addr_i;
                                wr_sel_s   = slot_onehot(free_s[S_WIDTH-1:0]);
                                wr_data_s  = {1'b1, cmd_value_i};
                                rsp_slot_s = free_s[S_WIDTH-1:0];
                                sh_set_s   = 1'b1;
                                sh_val_s   = 1'b1;
                                sh_slot_s  = free_s[S_WIDTH-1:0];
                            end else begin
                                err_s = 1'b1;
                            end
                        end
                        OP_CLEAR: begin
                            state_s      = ST_CLEAR;
                            wr_en_s      = 1'b1;
                            wr_sel_s     = {D_CNT{1'b1}};
                            done_s       = (LAST_ADDR == {A_WIDTH{1'b0}});
                            sh_clr_all_s = 1'b1;
                        end
                        default: begin
                            state_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    cmd_ready_s = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_s     = ST_IDLE;
                cmd_ready_s = 1'b1;
            end
            ST_CLEAR: begin
                // The sweep address lives in wr_addr_r; stop after the last entry.
                if (wr_addr_r == LAST_ADDR) begin
                    state_s     = ST_IDLE;
                    cmd_ready_s = 1'b1;
                end else begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = wr_addr_r + {{(A_WIDTH - 1){1'b0}}, 1'b1};
                    wr_sel_s  = {D_CNT{1'b1}};
                    done_s    = (wr_addr_s == LAST_ADDR);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b0;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= {A_WIDTH{1'b0}};
            wr_sel_r    <= {D_CNT{1'b0}};
            wr_data_r   <= {(D_WIDTH + 1){1'b0}};
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            rsp_slot_r  <= {S_WIDTH{1'b0}};
        end else begin
            state_r     <= state_s;
            cmd_ready_r <= cmd_ready_s;
            wr_en_r     <= wr_en_s;
            wr_addr_r   <= wr_addr_s;
            wr_sel_r    <= wr_sel_s;
            wr_data_r   <= wr_data_s;
            done_r      <= done_s;
            err_r       <= err_s;
            rsp_slot_r  <= rsp_slot_s;
        end
    end

    // Shadow valid bitmap: whole-array wipe on CLEAR accept, single-bit update otherwise.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                shadow_r[i] <= {D_CNT{1'b0}};
            end
        end else if (sh_clr_all_s) begin
            for (int i = 0; i < ENTRIES; i++) begin
                shadow_r[i] <= {D_CNT{1'b0}};
            end
        end else if (sh_set_s) begin
            shadow_r[cmd_addr_i][sh_slot_s] <= sh_val_s;
        end
    end

    assign cmd_ready_o = cmd_ready_r;
    assign wr_en_o     = wr_en_r;
    assign wr_addr_o   = wr_addr_r;
    assign wr_sel_o    = wr_sel_r;
    assign wr_data_o   = wr_data_r;
    assign done_o      = done_r;
    assign err_o       = err_r;
    assign rsp_slot_o  = rsp_slot_r;

endmodule

// File: tb/tb_qtree_match_wr.sv
// Bench for qtree_match_wr: a transaction-level model predicts every cycle's outputs,
// plus directed literal checks for the documented scenarios.
module tb_qtree_match_wr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [3:0]  cmd_addr = 4'h0;
    logic [1:0]  cmd_slot = 2'b00;
    logic [15:0] cmd_value = 16'h0000;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_sel;
    logic [16:0] wr_data;
    logic        done;
    logic        err;
    logic [1:0]  rsp_slot;

    qtree_match_wr dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr), .cmd_slot_i(cmd_slot),
        .cmd_value_i(cmd_value),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_sel_o(wr_sel), .wr_data_o(wr_data),
        .done_o(done), .err_o(err), .rsp_slot_o(rsp_slot)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr_en;
        logic [3:0]  addr;
        logic [3:0]  sel;
        logic [16:0] data;
        logic        done;
        logic        err;
        logic [1:0]  rsp;
    } rec_t;

    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   wr_cnt = 0;
    bit   chk_en = 1'b0;
    rec_t exp_q[$];
    rec_t cur = '0;
    logic m_ready = 1'b0;
    logic [3:0] m_sh [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Transaction model: on accept, queue one output record per busy cycle.
    initial begin
        rec_t r;
        bit   found;
        logic [1:0] fs;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                cur = '0;
                m_ready = 1'b0;
                for (int i = 0; i < 16; i++) m_sh[i] = 4'h0;
            end else begin
                if (cmd_valid && m_ready) begin
                    r = '0;
                    r.done = 1'b1;
                    case (cmd_op)
                        2'b00: begin
                            r.wr_en = 1'b1; r.addr = cmd_addr; r.sel = 4'b0001 << cmd_slot;
                            r.data = {1'b1, cmd_value}; r.rsp = cmd_slot;
                            m_sh[cmd_addr][cmd_slot] = 1'b1;
                            exp_q.push_back(r);
                        end
                        2'b01: begin
                            r.wr_en = 1'b1; r.addr = cmd_addr; r.sel = 4'b0001 << cmd_slot;
                            r.rsp = cmd_slot;
                            m_sh[cmd_addr][cmd_slot] = 1'b0;
                            exp_q.push_back(r);
                        end
                        2'b10: begin
                            found = 1'b0;
                            fs = 2'b00;
                            for (int i = 0; i < 4; i++) begin
                                if (!found && !m_sh[cmd_addr][i]) begin
                                    found = 1'b1;
                                    fs = 2'(i);
                                end
                            end
                            if (found) begin
                                r.wr_en = 1'b1; r.addr = cmd_addr; r.sel = 4'b0001 << fs;
                                r.data = {1'b1, cmd_value}; r.rsp = fs;
                                m_sh[cmd_addr][fs] = 1'b1;
                            end else begin
                                r.err = 1'b1;
                            end
                            exp_q.push_back(r);
                        end
                        default: begin
                            for (int i = 0; i < 16; i++) m_sh[i] = 4'h0;
                            for (int a = 0; a < 16; a++) begin
                                r = '0;
                                r.wr_en = 1'b1; r.addr = 4'(a); r.sel = 4'hF;
                                r.done = (a == 15);
                                exp_q.push_back(r);
                            end
                        end
                    endcase
                end
                if (exp_q.size() > 0) cur = exp_q.pop_front();
                else cur = '0;
                m_ready = (exp_q.size() == 0) && !cur.wr_en && !cur.done;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        logic [30:0] act, expv;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                act  = {cmd_ready, wr_en, wr_addr, wr_sel, wr_data, done, err, rsp_slot};
                expv = {m_ready, cur};
                checks++;
                if (act !== expv) begin
                    failures++;
                    $display("FAIL cycle_model: dut=%h model=%h at %0t", act, expv, $time);
                end
                if (done === 1'b1) done_cnt++;
                if (wr_en === 1'b1) wr_cnt++;
            end
        end
    end

    // Present a command and hold it until accepted; returns 1ns into the response cycle.
    task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [1:0] s,
                        input logic [15:0] v, input bit keep);
        bit ok;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_slot = s; cmd_value = v;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
        end
        chk("accept_timeout", 32'(ok), 32'd1);
        if (!keep) cmd_valid = 1'b0;
    endtask

    initial begin
        int d0, w0;
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_outs", 32'({wr_en, done, err, wr_addr, wr_sel, wr_data, rsp_slot}), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("ready_pre_edge", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk("ready_after_rel", 32'(cmd_ready), 32'd1);

        // CLEAR sweep
        send(2'b11, 4'h9, 2'b00, 16'h0000, 1'b0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("clr_addr", 32'(wr_addr), 32'(i));
            chk("clr_done", 32'(done), 32'(i == 15));
            chk("clr_strobe", 32'({cmd_ready, wr_en, wr_sel, wr_data}), 32'({1'b0, 1'b1, 4'hF, 17'h0}));
        end
        @(negedge clk);
        chk("clr_end", 32'({cmd_ready, wr_en}), 32'b10);

        // WRITE addr 3 slot 2
        send(2'b00, 4'h3, 2'b10, 16'hBEEF, 1'b0);
        @(negedge clk);
        chk("wr_en", 32'(wr_en), 32'd1);
        chk("wr_addr", 32'(wr_addr), 32'd3);
        chk("wr_sel", 32'(wr_sel), 32'b0100);
        chk("wr_data", 32'(wr_data), 32'h1BEEF);
        chk("wr_rsp", 32'({done, err, rsp_slot}), 32'b1_0_10);

        // Fill addr 7 via ALLOC
        for (int i = 0; i < 5; i++) begin
            send(2'b10, 4'h7, 2'b11, 16'(16'hA000 + i), 1'b0);
            @(negedge clk);
            if (i < 4) begin
                chk("alloc_slot", 32'({done, err, wr_en, rsp_slot}), 32'({3'b101, 2'(i)}));
            end else begin
                chk("alloc_full", 32'({done, err, wr_en, rsp_slot}), 32'b11000);
            end
        end

        // INVAL slot 1 then ALLOC reuses it
        send(2'b01, 4'h7, 2'b01, 16'hFFFF, 1'b0);
        @(negedge clk);
        chk("inval", 32'({wr_en, wr_sel, wr_data, err}), 32'({1'b1, 4'b0010, 17'h0, 1'b0}));
        send(2'b10, 4'h7, 2'b00, 16'h1234, 1'b0);
        @(negedge clk);
        chk("realloc", 32'({wr_en, wr_sel, rsp_slot, wr_data}), 32'({1'b1, 4'b0010, 2'b01, 17'h11234}));
        send(2'b01, 4'h4, 2'b11, 16'h0000, 1'b0);
        @(negedge clk);
        chk("inval_free", 32'({wr_en, done, err, wr_sel}), 32'({3'b110, 4'b1000}));

        // Back-to-back WRITEs with valid held high
        d0 = done_cnt;
        w0 = wr_cnt;
        send(2'b00, 4'h1, 2'b00, 16'h1111, 1'b1);
        send(2'b00, 4'h2, 2'b01, 16'h2222, 1'b1);
        send(2'b00, 4'h3, 2'b11, 16'h3333, 1'b0);
        repeat (3) @(negedge clk);
        chk("b2b_done", 32'(done_cnt - d0), 32'd3);
        chk("b2b_wr", 32'(wr_cnt - w0), 32'd3);

        send(2'b00, 4'h5, 2'b11, 16'h5555, 1'b0);
        send(2'b10, 4'h5, 2'b00, 16'h6666, 1'b0);
        @(negedge clk);
        chk("alloc_a5", 32'({wr_en, rsp_slot}), 32'b100);

        // Reset during the 5th CLEAR cycle
        send(2'b11, 4'h0, 2'b00, 16'h0000, 1'b0);
        repeat (4) @(posedge clk);
        #3 chk("clr5_addr", 32'(wr_addr), 32'd4);
        rst_n = 1'b0;
        #1 chk("abort", 32'({wr_en, done, cmd_ready}), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("abort_ready_lo", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk("abort_ready_hi", 32'(cmd_ready), 32'd1);
        send(2'b10, 4'h7, 2'b00, 16'h7777, 1'b0);
        @(negedge clk);
        chk("post_rst_a7", 32'({wr_en, rsp_slot}), 32'b100);
        send(2'b10, 4'h3, 2'b00, 16'h8888, 1'b0);
        @(negedge clk);
        chk("post_rst_a3", 32'({wr_en, rsp_slot, wr_addr}), 32'({3'b100, 4'h3}));

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
